// File: rtl/operand_bus_arbiter.sv
// Two-port round-robin operand bus arbiter with a bounded burst and a
// one-entry registered output stage feeding the ALU operand input.
module operand_bus_arbiter #(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready
);

    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);
    localparam logic [3:0] BURST_SAT = 4'd15;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } req_t;

    req_t [1:0]  req;
    logic        owner;
    logic [3:0]  burst_cnt;
    logic        load_ok;
    logic        gnt_vld;
    logic        gnt;
    logic [WIDTH-1:0] mux_data;

    assign req[0]  = '{valid: req0_valid, data: req0_data};
    assign req[1]  = '{valid: req1_valid, data: req1_data};
    assign load_ok = !out_valid || out_ready;

    always_comb begin
        gnt_vld = 1'b0;
        gnt     = owner;
        if (!reset && load_ok) begin
            unique case ({req[1].valid, req[0].valid})
                2'b01: begin gnt_vld = 1'b1; gnt = 1'b0; end
                2'b10: begin gnt_vld = 1'b1; gnt = 1'b1; end
                // Contention: owner keeps the bus until its burst is used up.
                2'b11: begin
                    gnt_vld = 1'b1;
                    gnt     = (burst_cnt < BURST_LIM) ? owner : !owner;
                end
                default: begin gnt_vld = 1'b0; gnt = owner; end
            endcase
        end
    end

    assign sel        = gnt;
    assign req0_ready = gnt_vld && !gnt;
    assign req1_ready = gnt_vld && gnt;
    assign mux_data   = req[sel].data;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
            owner     <= 1'b0;
            burst_cnt <= '0;
        end else if (load_ok) begin
            if (gnt_vld) begin
                out_valid <= 1'b1;
                out_data  <= mux_data;
                out_src   <= gnt;
                if (gnt == owner) begin
                    if (burst_cnt != BURST_SAT)
                        burst_cnt <= burst_cnt + 4'd1;
                end else begin
                    owner     <= gnt;
                    burst_cnt <= 4'd1;
                end
            end else begin
                // Nothing requested: drain the stage and restart the burst window.
                out_valid <= 1'b0;
                burst_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_operand_bus_arbiter.sv
// Directed, table-driven bench for operand_bus_arbiter (WIDTH=32, MAX_BURST=4).
module tb_operand_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        sel;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_src;
    logic        out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    operand_bus_arbiter #(.WIDTH(32), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .sel(sel),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        v0;
        logic [31:0] d0;
        logic        v1;
        logic [31:0] d1;
        logic        ordy;
        logic        e_r0;
        logic        e_r1;
        logic        e_ov;
        logic [31:0] e_od;
        logic        e_src;
    } vec_t;

    vec_t tbl[$];
    int   cont_lo, cont_hi;

    function automatic vec_t mk(logic rst, logic v0, logic [31:0] d0, logic v1, logic [31:0] d1,
                                logic ordy, logic e_r0, logic e_r1, logic e_ov,
                                logic [31:0] e_od, logic e_src);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.ordy = ordy;
        v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_ov = e_ov; v.e_od = e_od; v.e_src = e_src;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at posedge+1: drive, check readies/sel mid-cycle, then check the stage after the edge.
    task automatic apply(input vec_t v, input int idx);
        reset = v.rst; req0_valid = v.v0; req0_data = v.d0;
        req1_valid = v.v1; req1_data = v.d1; out_ready = v.ordy;
        #2;
        check($sformatf("v%0d.req0_ready", idx), {31'b0, req0_ready}, {31'b0, v.e_r0});
        check($sformatf("v%0d.req1_ready", idx), {31'b0, req1_ready}, {31'b0, v.e_r1});
        if (v.e_r0 || v.e_r1)
            check($sformatf("v%0d.sel", idx), {31'b0, sel}, {31'b0, v.e_r1});
        @(posedge clk);
        #1;
        check($sformatf("v%0d.out_valid", idx), {31'b0, out_valid}, {31'b0, v.e_ov});
        check($sformatf("v%0d.out_data", idx), out_data, v.e_od);
        check($sformatf("v%0d.out_src", idx), {31'b0, out_src}, {31'b0, v.e_src});
    endtask

    task automatic add_contention();
        cont_lo = tbl.size();
        tbl.push_back(mk(0, 1, 32'hA0, 1, 32'hB0, 1, 1, 0, 1, 32'hA0, 0));
        tbl.push_back(mk(0, 1, 32'hA1, 1, 32'hB0, 1, 1, 0, 1, 32'hA1, 0));
        tbl.push_back(mk(0, 1, 32'hA2, 1, 32'hB0, 1, 1, 0, 1, 32'hA2, 0));
        tbl.push_back(mk(0, 1, 32'hA3, 1, 32'hB0, 1, 1, 0, 1, 32'hA3, 0));
        tbl.push_back(mk(0, 1, 32'hA4, 1, 32'hB0, 1, 0, 1, 1, 32'hB0, 1));
        tbl.push_back(mk(0, 1, 32'hA4, 1, 32'hB1, 1, 0, 1, 1, 32'hB1, 1));
        tbl.push_back(mk(0, 1, 32'hA4, 1, 32'hB2, 1, 0, 1, 1, 32'hB2, 1));
        tbl.push_back(mk(0, 1, 32'hA4, 1, 32'hB3, 1, 0, 1, 1, 32'hB3, 1));
        tbl.push_back(mk(0, 1, 32'hA4, 1, 32'hB4, 1, 1, 0, 1, 32'hA4, 0));
        tbl.push_back(mk(0, 1, 32'hA5, 1, 32'hB4, 1, 1, 0, 1, 32'hA5, 0));
        tbl.push_back(mk(0, 1, 32'hA6, 1, 32'hB4, 1, 1, 0, 1, 32'hA6, 0));
        tbl.push_back(mk(0, 1, 32'hA7, 1, 32'hB4, 1, 1, 0, 1, 32'hA7, 0));
        cont_hi = tbl.size();
    endtask

    initial begin
        reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0; out_ready = 1'b0;

        // Reset held three cycles with both requesters valid.
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 1, 32'hA0, 1, 32'hB0, 1, 0, 0, 0, 32'h0, 0));
        // Contention from reset: first grant to req0, 4/4 alternation.
        add_contention();
        // Single-requester stream from req1, no gaps.
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk(0, 0, 32'h0, 1, 32'h10 + i, 1, 0, 1, 1, 32'h10 + i, 1));
        // Idle pop: stage drains, data/src held.
        tbl.push_back(mk(0, 0, 32'h0, 0, 32'h0, 1, 0, 0, 0, 32'h15, 1));
        // Backpressure: load 0xDEADBEEF, stall 5 cycles with both valid.
        tbl.push_back(mk(0, 1, 32'hDEADBEEF, 0, 32'h0, 1, 1, 0, 1, 32'hDEADBEEF, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 1, 32'h1, 1, 32'h22, 0, 0, 0, 1, 32'hDEADBEEF, 0));
        // Burst count held at 1 through the stall: req0 gets exactly 3 more.
        tbl.push_back(mk(0, 1, 32'h1, 1, 32'h22, 1, 1, 0, 1, 32'h1, 0));
        tbl.push_back(mk(0, 1, 32'h2, 1, 32'h22, 1, 1, 0, 1, 32'h2, 0));
        tbl.push_back(mk(0, 1, 32'h3, 1, 32'h22, 1, 1, 0, 1, 32'h3, 0));
        tbl.push_back(mk(0, 1, 32'h4, 1, 32'h22, 1, 0, 1, 1, 32'h22, 1));
        // Idle resets burst: 3 req0 transfers, idle, then req0 gets 4 before req1.
        tbl.push_back(mk(0, 1, 32'h30, 0, 32'h0, 1, 1, 0, 1, 32'h30, 0));
        tbl.push_back(mk(0, 1, 32'h31, 0, 32'h0, 1, 1, 0, 1, 32'h31, 0));
        tbl.push_back(mk(0, 1, 32'h32, 0, 32'h0, 1, 1, 0, 1, 32'h32, 0));
        tbl.push_back(mk(0, 0, 32'h0, 0, 32'h0, 1, 0, 0, 0, 32'h32, 0));
        tbl.push_back(mk(0, 1, 32'h33, 1, 32'h40, 1, 1, 0, 1, 32'h33, 0));
        tbl.push_back(mk(0, 1, 32'h34, 1, 32'h40, 1, 1, 0, 1, 32'h34, 0));
        tbl.push_back(mk(0, 1, 32'h35, 1, 32'h40, 1, 1, 0, 1, 32'h35, 0));
        tbl.push_back(mk(0, 1, 32'h36, 1, 32'h40, 1, 1, 0, 1, 32'h36, 0));
        tbl.push_back(mk(0, 1, 32'h37, 1, 32'h40, 1, 0, 1, 1, 32'h40, 1));

        @(posedge clk);
        #1;
        foreach (tbl[i])
            apply(tbl[i], i);

        // Reset mid-operation: stage is full (0x40 from req1, owner=1) and both requesters valid.
        reset = 1'b1; req0_valid = 1'b1; req0_data = 32'h37;
        req1_valid = 1'b1; req1_data = 32'h41; out_ready = 1'b0;
        #2;
        check("midrst.req0_ready", {31'b0, req0_ready}, 32'h0);
        check("midrst.req1_ready", {31'b0, req1_ready}, 32'h0);
        @(posedge clk);
        #1;
        check("midrst.out_valid", {31'b0, out_valid}, 32'h0);
        check("midrst.out_data", out_data, 32'h0);
        check("midrst.out_src", {31'b0, out_src}, 32'h0);
        // After release the contention pattern must restart from owner 0.
        for (int i = cont_lo; i < cont_hi; i++)
            apply(tbl[i], 1000 + i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
